pupil_frame_sequencer: RTL and testbench

PUPIL_FRAME_SEQUENCER -- requirements
Module: pupil_frame_sequencer

---
 rtl/pupil_pkg.sv | 17 +
 rtl/pupil_xy_counter.sv | 58 +++++
 rtl/pupil_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_pupil_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pupil_pkg.sv
// Shared definitions for the pupil frame sequencer: FSM state encoding,
// coordinate width and default image geometry.
package pupil_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned IMG_W_DEF = 320;
  localparam int unsigned IMG_H_DEF = 240;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_WAIT_CORE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pupil_xy_counter.sv
// Raster x/y/address counters for one frame, with first/last-of-row and
// last-of-frame decode of the current position.
module pupil_xy_counter
  import pupil_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned ADDR_W = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               sof,
  output logic               eol,
  output logic               eof
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);

  always_comb begin
    sof = (x == '0) && (y == '0);
    eol = (x == X_LAST);
    eof = eol && (y == Y_LAST);
  end

  // Address is a running count rather than y*IMG_W+x; it wraps to 0 with the frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (step) begin
      if (eol) begin
        x <= '0;
        if (eof) begin
          y    <= '0;
          addr <= '0;
        end else begin
          y    <= y + 1'b1;
          addr <= addr + 1'b1;
        end
      end else begin
        x    <= x + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pupil_frame_sequencer.sv
// Frame sequencer: streams one frame from memory to the pupil detection core
// and latches its centre result. Define SEQ_TIMEOUT_EN for the result watchdog.
module pupil_frame_sequencer
  import pupil_pkg::*;
#(
  parameter int unsigned IMG_W       = IMG_W_DEF,
  parameter int unsigned IMG_H       = IMG_H_DEF,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pix_ready,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  input  logic               core_done,
  input  logic [COORD_W-1:0] core_xcenter,
  input  logic [COORD_W-1:0] core_ycenter,
  output logic [COORD_W-1:0] xcenter,
  output logic [COORD_W-1:0] ycenter,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t state, state_nxt;

  logic               issue;
  logic               accept;
  logic               latch;
  logic               timeout_hit;
  logic [COORD_W-1:0] c_x, c_y;
  logic [ADDR_W-1:0]  c_addr;
  logic               c_sof, c_eol, c_eof;

  pupil_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_xy (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .step (issue),
    .x    (c_x),
    .y    (c_y),
    .addr (c_addr),
    .sof  (c_sof),
    .eol  (c_eol),
    .eof  (c_eof)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_SCAN;
      ST_SCAN:      if (issue && c_eof) state_nxt = ST_DRAIN;
      ST_DRAIN:     state_nxt = ST_WAIT_CORE;
      ST_WAIT_CORE: if (core_done || timeout_hit) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    issue     = (state == ST_SCAN) && pix_ready;
    accept    = (state == ST_IDLE) && start;
    latch     = (state == ST_WAIT_CORE) && core_done;
    mem_rd_en = issue;
    mem_addr  = c_addr;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
  end

  // Memory returns data one cycle after the strobe, so the pixel tags are delayed to match.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      pix_valid <= issue;
      sof       <= issue && c_sof;
      eol       <= issue && c_eol;
      eof       <= issue && c_eof;
      if (issue) begin
        pix_x <= c_x;
        pix_y <= c_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      xcenter <= '0;
      ycenter <= '0;
    end else if (latch) begin
      xcenter <= core_xcenter;
      ycenter <= core_ycenter;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wait_cnt;

  always_comb begin
    timeout_hit = (state == ST_WAIT_CORE) && !core_done &&
                  (wait_cnt == 32'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) wait_cnt <= '0;
    else if (state == ST_WAIT_CORE) wait_cnt <= wait_cnt + 1'b1;
    else wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) err <= 1'b0;
    else if (accept) err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
  end
`else
  logic unused_timeout_cfg;

  always_comb begin
    timeout_hit        = 1'b0;
    err                = 1'b0;
    unused_timeout_cfg = ^TIMEOUT_CYC;
  end
`endif

  a_done_single : assert property (@(posedge clk) disable iff (!rst) done |=> !done);
  a_pix_follows_issue : assert property (@(posedge clk) disable iff (!rst)
                                         mem_rd_en |=> pix_valid);

endmodule

// File: tb/tb_pupil_frame_sequencer.sv
// Self-checking bench for pupil_frame_sequencer on a 4x3 image: table-driven
// frame walk plus hand sequences, with a pixel scoreboard built from the strobes.
module tb_pupil_frame_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned N  = W * H;
  localparam int unsigned AW = 17;
  localparam int unsigned TO = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pix_ready = 1'b0;
  logic          core_done = 1'b0;
  logic [9:0]    core_xcenter = '0;
  logic [9:0]    core_ycenter = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          pix_valid;
  logic [9:0]    pix_x, pix_y;
  logic          sof, eol, eof;
  logic [9:0]    xcenter, ycenter;
  logic          busy, done, err;

  pupil_frame_sequencer #(
    .IMG_W      (W),
    .IMG_H      (H),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pix_ready   (pix_ready),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .sof         (sof),
    .eol         (eol),
    .eof         (eof),
    .core_done   (core_done),
    .core_xcenter(core_xcenter),
    .core_ycenter(core_ycenter),
    .xcenter     (xcenter),
    .ycenter     (ycenter),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic st, input logic pr, input logic cd,
                       input int cx, input int cy);
    @(negedge clk);
    rst = r; start = st; pix_ready = pr; core_done = cd;
    core_xcenter = 10'(cx); core_ycenter = 10'(cy);
    #1;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_flags"}, 32'({busy, done, mem_rd_en, pix_valid, sof, eol, eof, err}), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_pix_xy"}, 32'({pix_x, pix_y}), 0);
    chk({tag, "_centre"}, 32'({xcenter, ycenter}), 0);
  endtask

  // Pixel scoreboard: an expected pixel is queued on every strobe, consumed
  // when pix_valid appears the following cycle.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       f_sof;
    logic       f_eol;
    logic       f_eof;
  } pix_t;

  pix_t        sbq[$];
  pix_t        pe;
  int unsigned exp_addr = 0;
  int          pops = 0;
  int          eof_pops = 0;
  bit          mon_en = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (!rst) begin
        sbq.delete();
        exp_addr = 0;
      end else begin
        if (pix_valid) begin
          if (sbq.size() == 0) chk("pix_unexpected", 32'(pix_valid), 0);
          else begin
            pe = sbq.pop_front();
            pops++;
            if (pe.f_eof) eof_pops++;
            chk("pix_x", 32'(pix_x), 32'(pe.x));
            chk("pix_y", 32'(pix_y), 32'(pe.y));
            chk("pix_flags", 32'({sof, eol, eof}), 32'({pe.f_sof, pe.f_eol, pe.f_eof}));
          end
        end
        if (sbq.size() != 0) chk("pix_lost", 32'(sbq.size()), 0);
        if (mem_rd_en) begin
          chk("issue_addr", 32'(mem_addr), exp_addr);
          pe.x     = 10'(exp_addr % W);
          pe.y     = 10'(exp_addr / W);
          pe.f_sof = (exp_addr == 0);
          pe.f_eol = ((exp_addr % W) == W - 1);
          pe.f_eof = (exp_addr == N - 1);
          sbq.push_back(pe);
          exp_addr = (exp_addr + 1) % N;
        end
      end
    end
  end

  typedef struct {
    bit st, pr, cd;
    int cx, cy;
    bit e_busy, e_done, e_rd, e_pv;
    int e_addr, e_xc, e_yc;
  } vec_t;

  function automatic vec_t mk(bit st, bit pr, bit cd, int cx, int cy, bit eb, bit ed,
                              bit er, bit ep, int ea, int exc, int eyc);
    vec_t v;
    v.st = st; v.pr = pr; v.cd = cd; v.cx = cx; v.cy = cy;
    v.e_busy = eb; v.e_done = ed; v.e_rd = er; v.e_pv = ep;
    v.e_addr = ea; v.e_xc = exc; v.e_yc = eyc;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[24];
    int   ndone;
    int   done_at;

    // Full frame: stall at address 5 for 3 cycles, stray core_done and start mid-scan.
    vt[0]  = mk(1, 1, 0,   0,   0, 0, 0, 0, 0,  0,   0,  0);
    vt[1]  = mk(0, 1, 0,   0,   0, 1, 0, 1, 0,  0,   0,  0);
    vt[2]  = mk(0, 1, 0,   0,   0, 1, 0, 1, 1,  1,   0,  0);
    vt[3]  = mk(0, 1, 1, 500, 500, 1, 0, 1, 1,  2,   0,  0);
    vt[4]  = mk(0, 1, 0,   0,   0, 1, 0, 1, 1,  3,   0,  0);
    vt[5]  = mk(0, 1, 0,   0,   0, 1, 0, 1, 1,  4,   0,  0);
    vt[6]  = mk(0, 0, 0,   0,   0, 1, 0, 0, 1,  5,   0,  0);
    vt[7]  = mk(0, 0, 0,   0,   0, 1, 0, 0, 0,  5,   0,  0);
    vt[8]  = mk(0, 0, 0,   0,   0, 1, 0, 0, 0,  5,   0,  0);
    vt[9]  = mk(0, 1, 0,   0,   0, 1, 0, 1, 0,  5,   0,  0);
    vt[10] = mk(0, 1, 0,   0,   0, 1, 0, 1, 1,  6,   0,  0);
    vt[11] = mk(0, 1, 0,   0,   0, 1, 0, 1, 1,  7,   0,  0);
    vt[12] = mk(1, 1, 0,   0,   0, 1, 0, 1, 1,  8,   0,  0);
    vt[13] = mk(0, 1, 0,   0,   0, 1, 0, 1, 1,  9,   0,  0);
    vt[14] = mk(0, 1, 0,   0,   0, 1, 0, 1, 1, 10,   0,  0);
    vt[15] = mk(0, 1, 0,   0,   0, 1, 0, 1, 1, 11,   0,  0);
    vt[16] = mk(0, 1, 0,   0,   0, 1, 0, 0, 1,  0,   0,  0);
    vt[17] = mk(0, 1, 0,   0,   0, 1, 0, 0, 0,  0,   0,  0);
    vt[18] = mk(0, 1, 0,   0,   0, 1, 0, 0, 0,  0,   0,  0);
    vt[19] = mk(0, 1, 1, 123,  45, 1, 0, 0, 0,  0,   0,  0);
    vt[20] = mk(0, 1, 0,   0,   0, 1, 1, 0, 0,  0, 123, 45);
    vt[21] = mk(0, 1, 0,   0,   0, 0, 0, 0, 0,  0, 123, 45);
    vt[22] = mk(0, 1, 1,   7,   7, 0, 0, 0, 0,  0, 123, 45);
    vt[23] = mk(0, 1, 0,   0,   0, 0, 0, 0, 0,  0, 123, 45);

    mon_en = 1'b1;
    repeat (3) drive(0, 1, 1, 1, 9, 9);
    drive(1, 0, 1, 0, 0, 0);
    zero_check("after_reset");

    for (int i = 0; i < 24; i++) begin
      drive(1, vt[i].st, vt[i].pr, vt[i].cd, vt[i].cx, vt[i].cy);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vt[i].e_done));
      chk($sformatf("v%0d_rd", i), 32'(mem_rd_en), 32'(vt[i].e_rd));
      chk($sformatf("v%0d_pv", i), 32'(pix_valid), 32'(vt[i].e_pv));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), vt[i].e_addr);
      chk($sformatf("v%0d_xc", i), 32'(xcenter), vt[i].e_xc);
      chk($sformatf("v%0d_yc", i), 32'(ycenter), vt[i].e_yc);
    end

    // Frame with no core result.
    ndone = 0; done_at = -1;
    drive(1, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      drive(1, 0, 1, 0, 0, 0);
      if (done) begin ndone++; done_at = i; end
`ifdef SEQ_TIMEOUT_EN
      if (i == int'(N + 2 + TO)) begin
        chk("timeout_err", 32'(err), 1);
        chk("timeout_keep_xc", 32'(xcenter), 123);
        chk("timeout_keep_yc", 32'(ycenter), 45);
      end
`endif
    end
`ifdef SEQ_TIMEOUT_EN
    chk("timeout_done_at", 32'(done_at), N + 2 + TO);
    chk("timeout_ndone", 32'(ndone), 1);
    chk("timeout_err_sticky", 32'(err), 1);
`else
    chk("nowatchdog_ndone", 32'(ndone), 0);
    chk("nowatchdog_busy", 32'(busy), 1);
    chk("nowatchdog_err", 32'(err), 0);
    drive(1, 0, 1, 1, 400, 401);
    drive(1, 0, 1, 0, 0, 0);
    chk("late_done", 32'(done), 1);
    chk("late_xc", 32'(xcenter), 400);
    chk("late_yc", 32'(ycenter), 401);
    drive(1, 0, 1, 0, 0, 0);
`endif

    // start and core_done held high: latency N+3, one frame, restart after IDLE.
    ndone = 0; done_at = -1;
    for (int i = 0; i <= 16; i++) begin
      drive(1, 1, 1, 1, 300, 200);
      if (i == 1) chk("err_cleared_by_start", 32'(err), 0);
      if (done) begin ndone++; done_at = i; end
      if (i == 16) chk("held_start_idle_busy", 32'(busy), 0);
    end
    chk("latency_done_at", 32'(done_at), N + 3);
    chk("held_start_ndone", 32'(ndone), 1);
    chk("held_start_xc", 32'(xcenter), 300);
    chk("held_start_yc", 32'(ycenter), 200);
    drive(1, 0, 1, 0, 0, 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_rd", 32'(mem_rd_en), 1);
    chk("restart_addr", 32'(mem_addr), 0);

    // Reset mid-frame while address 7 is being issued.
    for (int k = 0; k < 20 && !(mem_rd_en && mem_addr == 6); k++) drive(1, 0, 1, 0, 0, 0);
    chk("reach_addr6", 32'(mem_addr), 6);
    drive(0, 0, 1, 0, 0, 0);
    chk("rst_at_addr7", 32'(mem_addr), 7);
    drive(1, 0, 1, 0, 0, 0);
    zero_check("mid_frame_reset");
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 0, 1, 1, 55, 66);
    chk("rescan_rd", 32'(mem_rd_en), 1);
    chk("rescan_addr", 32'(mem_addr), 0);
    ndone = 0;
    for (int k = 0; k < 30 && ndone == 0; k++) begin
      drive(1, 0, 1, 1, 55, 66);
      if (done) ndone++;
    end
    chk("rescan_done", 32'(ndone), 1);
    chk("rescan_xc", 32'(xcenter), 55);
    chk("rescan_yc", 32'(ycenter), 66);

    repeat (3) drive(1, 0, 1, 0, 0, 0);
    chk("total_pixels", 32'(pops), 4 * N + 6);
    chk("total_eof", 32'(eof_pops), 4);
    chk("scoreboard_empty", 32'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
